mem_stage_ctrl: RTL and testbench
=================================

// Module: mem_stage_ctrl
// PURPOSE
//  Memory-stage access controller. Sits between the EX/MEM pipeline register and the MEM/WB register.
//  Turns the latched load/store into a dcache request, holds it until dhit, and presents a stable load word.
//  Produces the MEM/WB enable and the memory-stall request. Counts accesses and miss-stall cycles for perf.
// PARAMETERS
//  CNT_W  32  width of the saturating perf counters acc_cnt and stall_cnt
// PORTS
//  CLK           in   1      system clock, all state on rising edge
//  nRST          in   1      asynchronous, active-low reset
//  dREN_ex       in   1      EX/MEM: instruction is a load
//  dWEN_ex       in   1      EX/MEM: instruction is a store
//  daddr_ex      in   32     EX/MEM: effective address
//  dstore_ex     in   32     EX/MEM: store data
//  pipe_go       in   1      hazard unit: pipeline may advance this cycle, excluding the memory stall
//  dhit          in   1      dcache: request completed this cycle
//  dmemload      in   32     dcache: load data, valid when dhit
//  dmemREN       out  1      dcache read request
//  dmemWEN       out  1      dcache write request
//  dmemaddr      out  32     dcache address
//  dmemstore     out  32     dcache write data
//  dmemload_mem  out  32     load word presented to MEM/WB (dmemload input there)
//  mem_stall     out  1      memory stage holds the pipeline
//  enable_memwb  out  1      MEM/WB register load enable
//  acc_cnt       out  CNT_W  completed accesses, saturating
//  stall_cnt     out  CNT_W  cycles with mem_stall=1, saturating
// BEHAVIOUR
//  op = dREN_ex|dWEN_ex. dREN_ex and dWEN_ex are never both 1; if they are, the read wins and WEN is masked.
//  FSM states: IDLE, WAIT, DONE. Reset state is IDLE.
//  IDLE: if op=1, drive the request combinationally in the same cycle.
//    dhit=1 that cycle: complete. Next state is IDLE if pipe_go=1, else DONE.
//    dhit=0 that cycle: next state is WAIT.
//  WAIT: request held with a constant address and data. On dhit, complete.
//    Next state is IDLE if pipe_go=1, else DONE. Stays in WAIT while dhit=0.
//  DONE: the instruction is already serviced and waits for advance. No request is issued (no double store).
//    pipe_go=1 moves DONE to IDLE.
//  Request is active in IDLE with op=1, and in WAIT.
//    dmemREN/dmemWEN follow dREN_ex/dWEN_ex when the request is active, else 0.
//    dmemaddr=daddr_ex and dmemstore=dstore_ex always.
//  mem_stall = request_active & ~dhit.
//  enable_memwb = pipe_go & ~mem_stall.
//  load_q: 32-bit register captured on every completion with dREN_ex=1.
//  dmemload_mem = dmemload when dhit=1 and the read request is active; otherwise load_q.
//    This holds the word stable in DONE.
//  Stores ignore dmemload. load_q keeps its old value.
//  acc_cnt +1 on every completion; stall_cnt +1 every cycle mem_stall=1. Both hold at 2^CNT_W-1.
//  A dhit with no active request (IDLE with op=0, or DONE) is ignored: no capture, no count, no transition.
//  pipe_go=0 while in WAIT: the stall continues. On dhit, go to DONE and keep the data.
//  Reset (nRST=0) at any point, including mid-WAIT, acts immediately and asynchronously:
//    state=IDLE, load_q=0, acc_cnt=0, stall_cnt=0.
//    Request outputs drop to 0 for the reset duration. The cache must tolerate a withdrawn request.
//  Output values under reset: dmemREN=0, dmemWEN=0, mem_stall=0, enable_memwb=pipe_go, dmemload_mem=0.
//  Latency: a hit completes in 0 extra cycles. A miss of N cycles gives exactly N cycles of mem_stall=1.
// TESTING
//  1. Reset, then a load at 0x40 with dhit=1 in the same cycle, dmemload=0xDEADBEEF, pipe_go=1
//     -> enable_memwb=1 that cycle, dmemload_mem=0xDEADBEEF, mem_stall=0, acc_cnt=1.
//  2. Load miss with dhit delayed 3 cycles, pipe_go=1
//     -> mem_stall=1 for 3 cycles, dmemREN held, address constant.
//     -> enable_memwb=1 on the dhit cycle, stall_cnt=3.
//  3. Store hit with pipe_go=0 for 2 cycles after dhit
//     -> FSM in DONE, dmemWEN=0 in both cycles (no re-write).
//     -> on pipe_go=1, returns to IDLE; acc_cnt increments by exactly 1.
//  4. Load hit with data 0x12345678 and pipe_go=0, then dmemload changes to 0xFFFFFFFF
//     -> dmemload_mem stays 0x12345678 until advance.
//  5. nRST asserted mid-WAIT
//     -> dmemREN=0 immediately, counters 0, state IDLE.
//     -> after release, the same op re-requests in the first cycle.
//  6. Force stall_cnt near 2^CNT_W-1 (CNT_W=4), then a long miss
//     -> stall_cnt saturates at 15 and does not wrap.

Source files
------------

// File: rtl/mem_stage_ctrl.sv
// Memory-stage access controller: issues the dcache request for the latched load/store,
// holds it until dhit, keeps the load word stable, and drives stall / MEM/WB enable and perf counters.
module mem_stage_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             dREN_ex,
  input  logic             dWEN_ex,
  input  logic [31:0]      daddr_ex,
  input  logic [31:0]      dstore_ex,
  input  logic             pipe_go,
  input  logic             dhit,
  input  logic [31:0]      dmemload,
  output logic             dmemREN,
  output logic             dmemWEN,
  output logic [31:0]      dmemaddr,
  output logic [31:0]      dmemstore,
  output logic [31:0]      dmemload_mem,
  output logic             mem_stall,
  output logic             enable_memwb,
  output logic [CNT_W-1:0] acc_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [31:0]      load_q, load_d;
  logic [CNT_W-1:0] acc_cnt_q, acc_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic op;
  logic req_active;
  logic complete;

  // The request is gated by nRST so it is withdrawn for the whole reset interval.
  assign op         = dREN_ex | dWEN_ex;
  assign req_active = nRST & (((state_q == IDLE) & op) | (state_q == WAIT));
  assign complete   = req_active & dhit;

  assign dmemREN      = req_active & dREN_ex;
  assign dmemWEN      = req_active & dWEN_ex & ~dREN_ex;
  assign dmemaddr     = daddr_ex;
  assign dmemstore    = dstore_ex;
  assign mem_stall    = req_active & ~dhit;
  assign enable_memwb = pipe_go & ~mem_stall;
  assign dmemload_mem = (dhit & dmemREN) ? dmemload : load_q;
  assign acc_cnt      = acc_cnt_q;
  assign stall_cnt    = stall_cnt_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (complete)        state_d = pipe_go ? IDLE : DONE;
        else if (req_active) state_d = WAIT;
      end
      WAIT: begin
        if (complete) state_d = pipe_go ? IDLE : DONE;
      end
      DONE: begin
        if (pipe_go) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    load_d      = load_q;
    acc_cnt_d   = acc_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (complete && dREN_ex)
      load_d = dmemload;
    if (complete && (acc_cnt_q != {CNT_W{1'b1}}))
      acc_cnt_d = acc_cnt_q + CNT_W'(1);
    if (mem_stall && (stall_cnt_q != {CNT_W{1'b1}}))
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= IDLE;
      load_q      <= '0;
      acc_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      load_q      <= load_d;
      acc_cnt_q   <= acc_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed self-checking bench for mem_stage_ctrl, built with CNT_W=4 so counter saturation is reachable.
module tb_mem_stage_ctrl;

  localparam int CNT_W = 4;

  logic             CLK;
  logic             nRST;
  logic             dREN_ex;
  logic             dWEN_ex;
  logic [31:0]      daddr_ex;
  logic [31:0]      dstore_ex;
  logic             pipe_go;
  logic             dhit;
  logic [31:0]      dmemload;
  logic             dmemREN;
  logic             dmemWEN;
  logic [31:0]      dmemaddr;
  logic [31:0]      dmemstore;
  logic [31:0]      dmemload_mem;
  logic             mem_stall;
  logic             enable_memwb;
  logic [CNT_W-1:0] acc_cnt;
  logic [CNT_W-1:0] stall_cnt;

  int tests;
  int failed;

  mem_stage_ctrl #(.CNT_W(CNT_W)) dut (
    .CLK(CLK), .nRST(nRST),
    .dREN_ex(dREN_ex), .dWEN_ex(dWEN_ex), .daddr_ex(daddr_ex), .dstore_ex(dstore_ex),
    .pipe_go(pipe_go), .dhit(dhit), .dmemload(dmemload),
    .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
    .dmemload_mem(dmemload_mem), .mem_stall(mem_stall), .enable_memwb(enable_memwb),
    .acc_cnt(acc_cnt), .stall_cnt(stall_cnt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Advance one rising edge, then settle 1 time unit past it.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    dREN_ex = 0; dWEN_ex = 0; dhit = 0; dmemload = 32'h0;
  endtask

  task automatic test_reset();
    nRST = 0; idle_inputs(); pipe_go = 1;
    daddr_ex = 32'h0; dstore_ex = 32'h0;
    step();
    dREN_ex = 1; #1;
    tests++; if (dmemREN !== 1'b0) begin failed++; $display("[TB] FAIL reset_ren got %b exp 0", dmemREN); end
    tests++; if (mem_stall !== 1'b0) begin failed++; $display("[TB] FAIL reset_stall got %b exp 0", mem_stall); end
    tests++; if (enable_memwb !== 1'b1) begin failed++; $display("[TB] FAIL reset_en got %b exp 1", enable_memwb); end
    tests++; if (dmemload_mem !== 32'h0) begin failed++; $display("[TB] FAIL reset_load got %h exp 0", dmemload_mem); end
    tests++; if (acc_cnt !== 4'd0 || stall_cnt !== 4'd0) begin failed++; $display("[TB] FAIL reset_cnt got %0d/%0d exp 0/0", acc_cnt, stall_cnt); end
    dREN_ex = 0;
    step();
    nRST = 1;
  endtask

  task automatic test_load_hit();
    dREN_ex = 1; daddr_ex = 32'h40; dhit = 1; dmemload = 32'hDEADBEEF; pipe_go = 1; #2;
    tests++; if (dmemREN !== 1'b1 || dmemaddr !== 32'h40) begin failed++; $display("[TB] FAIL hit_req got ren=%b addr=%h exp 1/40", dmemREN, dmemaddr); end
    tests++; if (enable_memwb !== 1'b1 || mem_stall !== 1'b0) begin failed++; $display("[TB] FAIL hit_en got en=%b stall=%b exp 1/0", enable_memwb, mem_stall); end
    tests++; if (dmemload_mem !== 32'hDEADBEEF) begin failed++; $display("[TB] FAIL hit_data got %h exp deadbeef", dmemload_mem); end
    step();
    idle_inputs(); #1;
    tests++; if (acc_cnt !== 4'd1) begin failed++; $display("[TB] FAIL hit_acc got %0d exp 1", acc_cnt); end
    tests++; if (dmemload_mem !== 32'hDEADBEEF) begin failed++; $display("[TB] FAIL hit_held got %h exp deadbeef", dmemload_mem); end
  endtask

  task automatic test_load_miss();
    dREN_ex = 1; daddr_ex = 32'h80; dhit = 0; pipe_go = 1; #1;
    for (int i = 0; i < 3; i++) begin
      tests++; if (mem_stall !== 1'b1 || enable_memwb !== 1'b0) begin failed++; $display("[TB] FAIL miss_stall%0d got stall=%b en=%b exp 1/0", i, mem_stall, enable_memwb); end
      tests++; if (dmemREN !== 1'b1 || dmemaddr !== 32'h80) begin failed++; $display("[TB] FAIL miss_req%0d got ren=%b addr=%h exp 1/80", i, dmemREN, dmemaddr); end
      step();
    end
    dhit = 1; dmemload = 32'hCAFEF00D; #1;
    tests++; if (mem_stall !== 1'b0 || enable_memwb !== 1'b1) begin failed++; $display("[TB] FAIL miss_done got stall=%b en=%b exp 0/1", mem_stall, enable_memwb); end
    tests++; if (dmemload_mem !== 32'hCAFEF00D) begin failed++; $display("[TB] FAIL miss_data got %h exp cafef00d", dmemload_mem); end
    step();
    idle_inputs(); #1;
    tests++; if (stall_cnt !== 4'd3 || acc_cnt !== 4'd2) begin failed++; $display("[TB] FAIL miss_cnt got stall=%0d acc=%0d exp 3/2", stall_cnt, acc_cnt); end
  endtask

  task automatic test_store_done();
    dWEN_ex = 1; daddr_ex = 32'hC0; dstore_ex = 32'h55AA; dhit = 1; pipe_go = 0; #1;
    tests++; if (dmemWEN !== 1'b1 || dmemstore !== 32'h55AA || enable_memwb !== 1'b0) begin failed++; $display("[TB] FAIL st_req got wen=%b data=%h en=%b exp 1/55aa/0", dmemWEN, dmemstore, enable_memwb); end
    for (int i = 0; i < 2; i++) begin
      step();
      tests++; if (dmemWEN !== 1'b0 || mem_stall !== 1'b0) begin failed++; $display("[TB] FAIL st_done%0d got wen=%b stall=%b exp 0/0", i, dmemWEN, mem_stall); end
    end
    tests++; if (acc_cnt !== 4'd3) begin failed++; $display("[TB] FAIL st_acc_hold got %0d exp 3", acc_cnt); end
    pipe_go = 1; #1;
    tests++; if (enable_memwb !== 1'b1 || dmemWEN !== 1'b0) begin failed++; $display("[TB] FAIL st_adv got en=%b wen=%b exp 1/0", enable_memwb, dmemWEN); end
    step();
    dhit = 0; #1;
    tests++; if (dmemWEN !== 1'b1 || mem_stall !== 1'b1) begin failed++; $display("[TB] FAIL st_idle got wen=%b stall=%b exp 1/1", dmemWEN, mem_stall); end
    idle_inputs(); #1;
    tests++; if (acc_cnt !== 4'd3) begin failed++; $display("[TB] FAIL st_acc got %0d exp 3", acc_cnt); end
    tests++; if (dmemload_mem !== 32'hCAFEF00D) begin failed++; $display("[TB] FAIL st_load_kept got %h exp cafef00d", dmemload_mem); end
  endtask

  task automatic test_load_hold();
    dREN_ex = 1; daddr_ex = 32'h44; dhit = 1; dmemload = 32'h12345678; pipe_go = 0; #1;
    tests++; if (dmemload_mem !== 32'h12345678) begin failed++; $display("[TB] FAIL hold_hit got %h exp 12345678", dmemload_mem); end
    step();
    dmemload = 32'hFFFFFFFF;
    for (int i = 0; i < 2; i++) begin
      #1;
      tests++; if (dmemload_mem !== 32'h12345678 || dmemREN !== 1'b0) begin failed++; $display("[TB] FAIL hold_done%0d got data=%h ren=%b exp 12345678/0", i, dmemload_mem, dmemREN); end
      if (i == 0) dhit = 0;
      step();
    end
    pipe_go = 1; #1;
    tests++; if (enable_memwb !== 1'b1 || dmemload_mem !== 32'h12345678) begin failed++; $display("[TB] FAIL hold_adv got en=%b data=%h exp 1/12345678", enable_memwb, dmemload_mem); end
    step();
    idle_inputs(); #1;
    tests++; if (acc_cnt !== 4'd4) begin failed++; $display("[TB] FAIL hold_acc got %0d exp 4", acc_cnt); end
  endtask

  task automatic test_reset_mid_wait();
    dREN_ex = 1; daddr_ex = 32'h100; dhit = 0; pipe_go = 1;
    step();
    tests++; if (mem_stall !== 1'b1) begin failed++; $display("[TB] FAIL rw_wait got %b exp 1", mem_stall); end
    nRST = 0; #1;
    tests++; if (dmemREN !== 1'b0 || mem_stall !== 1'b0) begin failed++; $display("[TB] FAIL rw_drop got ren=%b stall=%b exp 0/0", dmemREN, mem_stall); end
    tests++; if (acc_cnt !== 4'd0 || stall_cnt !== 4'd0 || dmemload_mem !== 32'h0) begin failed++; $display("[TB] FAIL rw_clear got acc=%0d stall=%0d load=%h exp 0/0/0", acc_cnt, stall_cnt, dmemload_mem); end
    step();
    nRST = 1; #1;
    tests++; if (dmemREN !== 1'b1 || mem_stall !== 1'b1) begin failed++; $display("[TB] FAIL rw_rereq got ren=%b stall=%b exp 1/1", dmemREN, mem_stall); end
    dhit = 1; dmemload = 32'hA5A5A5A5;
    step();
    idle_inputs(); #1;
    tests++; if (acc_cnt !== 4'd1 || stall_cnt !== 4'd0 || dmemload_mem !== 32'hA5A5A5A5) begin failed++; $display("[TB] FAIL rw_after got acc=%0d stall=%0d load=%h exp 1/0/a5a5a5a5", acc_cnt, stall_cnt, dmemload_mem); end
  endtask

  task automatic test_stall_saturate();
    int expected;
    dREN_ex = 1; daddr_ex = 32'h200; dhit = 0; pipe_go = 1;
    for (int i = 1; i <= 20; i++) begin
      step();
      expected = (i > 15) ? 15 : i;
      if (i >= 13) begin
        tests++; if (stall_cnt !== 4'(expected)) begin failed++; $display("[TB] FAIL sat_cyc%0d got %0d exp %0d", i, stall_cnt, expected); end
      end
    end
    dhit = 1;
    step();
    idle_inputs(); #1;
    tests++; if (stall_cnt !== 4'd15 || acc_cnt !== 4'd2) begin failed++; $display("[TB] FAIL sat_end got stall=%0d acc=%0d exp 15/2", stall_cnt, acc_cnt); end
  endtask

  initial begin
    tests = 0;
    failed = 0;
    test_reset();
    test_load_hit();
    test_load_miss();
    test_store_done();
    test_load_hold();
    test_reset_mid_wait();
    test_stall_saturate();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
